// File: rtl/csa_word_sequencer.sv
// ---------------------------------------------------------------------------
// csa_word_sequencer
//   Multi-cycle word adder built around an external 4-bit carry select adder.
//   One W-bit operand pair (W = 4*WORDS) is accepted over a valid/ready
//   handshake, fed through the csa one 4-bit slice per clock with the carry
//   rippled in a register, and the assembled sum is returned over an output
//   valid/ready handshake.
//
//   Optional build macro: CSA_SEQ_OVF_EN
//     When defined, adds o_result_ovf, the two's-complement signed overflow
//     of the W-bit add, captured alongside the result.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready=1, csa inputs forced to 0
//   RUN   | one slice per cycle through the csa, idx selects the slice
//   DONE  | result presented with out_valid=1, held until out_ready
// ---------------------------------------------------------------------------
module csa_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [4*WORDS-1:0] i_op_a,
    input  logic [4*WORDS-1:0] i_op_b,
    input  logic               i_op_cin,
    output logic [3:0]         o_csa_a,
    output logic [3:0]         o_csa_b,
    output logic               o_csa_cin,
    input  logic [3:0]         i_csa_sum,
    input  logic               i_csa_cout,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [4*WORDS-1:0] o_result,
`ifdef CSA_SEQ_OVF_EN
    output logic               o_result_ovf,
`endif
    output logic               o_result_cout
);

    localparam int W     = 4 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_result_cout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [3:0]       w_a_slice;
    logic [3:0]       w_b_slice;
    logic             w_run;
    logic             w_accept;
    logic             w_last;

`ifdef CSA_SEQ_OVF_EN
    logic             r_result_ovf;
    logic             w_ovf;

    // Signed overflow: operands share a sign but the top sum bit differs.
    assign w_ovf = (r_a[W-1] == r_b[W-1]) && (i_csa_sum[3] != r_a[W-1]);
`endif

    assign w_run    = (r_state == S_RUN);
    assign w_accept = i_in_valid && r_in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // Slice mux written as a compare loop so non power-of-two WORDS never
    // selects past the end of the operand.
    always_comb begin
        w_a_slice = 4'd0;
        w_b_slice = 4'd0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_slice = r_a[4*k +: 4];
                w_b_slice = r_b[4*k +: 4];
            end
        end
    end

    // Drive the csa only while running; zeros keep it quiet otherwise.
    always_comb begin
        o_csa_a   = 4'd0;
        o_csa_b   = 4'd0;
        o_csa_cin = 1'b0;
        if (w_run) begin
            o_csa_a   = w_a_slice;
            o_csa_b   = w_b_slice;
            o_csa_cin = r_carry;
        end
    end

    // Sequencer FSM with registered handshake outputs and datapath capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_result_cout <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            r_result_ovf  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= i_op_a;
                        r_b        <= i_op_b;
                        r_carry    <= i_op_cin;
                        r_idx      <= '0;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
                        r_result_ovf <= 1'b0;
`endif
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_result[4*k +: 4] <= i_csa_sum;
                        end
                    end
                    r_carry <= i_csa_cout;
                    if (w_last) begin
                        r_result_cout <= i_csa_cout;
                        r_idx         <= '0;
                        r_out_valid   <= 1'b1;
`ifdef CSA_SEQ_OVF_EN
                        r_result_ovf  <= w_ovf;
`endif
                        r_state       <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                S_DONE: begin
                    // No overlap: in_ready only returns once back in IDLE.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_result      = r_result;
    assign o_result_cout = r_result_cout;
`ifdef CSA_SEQ_OVF_EN
    assign o_result_ovf  = r_result_ovf;
`endif

endmodule

// File: tb/tb_csa_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csa_word_sequencer
//   Directed bench for csa_word_sequencer. Two instances: WORDS=4 (main) and
//   WORDS=1 (single-slice corner). Each is closed around a behavioural 4-bit
//   adder standing in for the csa. With CSA_SEQ_OVF_EN defined the overflow
//   output is connected and checked as well.
// ---------------------------------------------------------------------------
module tb_csa_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    // WORDS=4 instance
    logic        in_valid, in_ready, op_cin, out_valid, out_ready, result_cout;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  csa_a, csa_b, csa_sum;
    logic        csa_cin, csa_cout;
    logic        result_ovf;

    // WORDS=1 instance
    logic        in_valid1, in_ready1, op_cin1, out_valid1, out_ready1, result_cout1;
    logic [3:0]  op_a1, op_b1, result1;
    logic [3:0]  csa_a1, csa_b1, csa_sum1;
    logic        csa_cin1, csa_cout1;
    logic        result_ovf1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign {csa_cout, csa_sum}   = 5'(csa_a)  + 5'(csa_b)  + 5'(csa_cin);
    assign {csa_cout1, csa_sum1} = 5'(csa_a1) + 5'(csa_b1) + 5'(csa_cin1);

`ifndef CSA_SEQ_OVF_EN
    assign result_ovf  = 1'b0;
    assign result_ovf1 = 1'b0;
`endif

    csa_word_sequencer #(.WORDS(4)) u_dut4 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .i_op_cin     (op_cin),
        .o_csa_a      (csa_a),
        .o_csa_b      (csa_b),
        .o_csa_cin    (csa_cin),
        .i_csa_sum    (csa_sum),
        .i_csa_cout   (csa_cout),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_result     (result),
`ifdef CSA_SEQ_OVF_EN
        .o_result_ovf (result_ovf),
`endif
        .o_result_cout(result_cout)
    );

    csa_word_sequencer #(.WORDS(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid1),
        .o_in_ready   (in_ready1),
        .i_op_a       (op_a1),
        .i_op_b       (op_b1),
        .i_op_cin     (op_cin1),
        .o_csa_a      (csa_a1),
        .o_csa_b      (csa_b1),
        .o_csa_cin    (csa_cin1),
        .i_csa_sum    (csa_sum1),
        .i_csa_cout   (csa_cout1),
        .o_out_valid  (out_valid1),
        .i_out_ready  (out_ready1),
        .o_result     (result1),
`ifdef CSA_SEQ_OVF_EN
        .o_result_ovf (result_ovf1),
`endif
        .o_result_cout(result_cout1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction on the WORDS=4 instance. Slice and carry expectations
    // come from bench arithmetic on the operands; the final sum is hand-given.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_res,
                          input logic exp_cout, input logic exp_ovf);
        int mask;
        int exp_carry;
        out_ready = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // later operand changes must not leak into the running add
        op_a = ~a; op_b = ~b; op_cin = ~cin;
        for (int k = 0; k < 4; k++) begin
            mask      = (1 << (4*k)) - 1;
            exp_carry = (((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> (4*k)) & 1;
            chk($sformatf("%s_run%0d_in_ready", tag, k), 32'(in_ready), 32'd0);
            chk($sformatf("%s_run%0d_out_valid", tag, k), 32'(out_valid), 32'd0);
            chk($sformatf("%s_run%0d_csa_a", tag, k), 32'(csa_a), 32'((a >> (4*k)) & 16'hF));
            chk($sformatf("%s_run%0d_csa_b", tag, k), 32'(csa_b), 32'((b >> (4*k)) & 16'hF));
            chk($sformatf("%s_run%0d_csa_cin", tag, k), 32'(csa_cin), 32'(exp_carry));
            step();
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_cout"}, 32'(result_cout), 32'(exp_cout));
        chk({tag, "_done_csa_a"}, 32'(csa_a), 32'd0);
`ifdef CSA_SEQ_OVF_EN
        chk({tag, "_ovf"}, 32'(result_ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        step();
        chk({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; op_a1 = '0; op_b1 = '0; op_cin1 = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(result_cout), 32'd0);
        chk("rst_csa", {csa_a, csa_b, 7'd0, csa_cin}, 16'd0);
        chk("rst_ovf", 32'(result_ovf), 32'd0);
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
        rst = 1'b0;
        step();

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

        // Backpressure: DONE must hold while inputs churn.
        op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_result", k), 32'(result), 32'h3333);
            op_a = 16'hA5A5 ^ 16'(k); in_valid = ~in_valid;
            step();
        end
        chk("bp_hold_result", 32'(result), 32'h3333);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_result", 32'(result), 32'h3333);

        // Reset during the second RUN cycle discards the add.
        op_a = 16'h0FFF; op_b = 16'h0001; op_cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_run2_csa_cin", 32'(csa_cin), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_csa", {csa_a, csa_b, 7'd0, csa_cin}, 16'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mid_rst_quiet%0d", k), 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Signed overflow cases (ovf only checked when the feature is built).
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // WORDS=1: single RUN cycle then DONE.
        op_a1 = 4'h9; op_b1 = 4'h8; op_cin1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0; op_a1 = 4'h0;
        chk("w1_run_csa_a", 32'(csa_a1), 32'h9);
        chk("w1_run_out_valid", 32'(out_valid1), 32'd0);
        step();
        chk("w1_out_valid", 32'(out_valid1), 32'd1);
        chk("w1_result", 32'(result1), 32'h1);
        chk("w1_cout", 32'(result_cout1), 32'd1);
`ifdef CSA_SEQ_OVF_EN
        chk("w1_ovf", 32'(result_ovf1), 32'd1);
`endif
        step();
        chk("w1_release", {out_valid1, in_ready1}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_word_sequencer.md
Name: csa_word_sequencer

Overview:
- Multi-cycle controller wrapped around the 4-bit carry select adder (csa). It sits directly upstream and downstream of the csa.
- Accepts one wide operand pair over a valid/ready handshake. Drives one 4-bit slice per cycle into the csa (a, b, cin) and captures the csa sum/cout.
- Ripples the carry between slices in a register and presents the assembled W-bit result over an output valid/ready handshake.

Parameters:
- WORDS, 4, number of 4-bit slices (W = 4*WORDS); legal range 1..16.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- op_a  input  W  operand A
- op_b  input  W  operand B
- op_cin  input  1  carry-in for slice 0
- csa_a  output  4  to csa a
- csa_b  output  4  to csa b
- csa_cin  output  1  to csa cin
- csa_sum  input  4  from csa sum (combinational)
- csa_cout  input  1  from csa cout (combinational)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  W  assembled sum
- result_cout  output  1  carry-out of the top slice

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, result=0, result_cout=0.
  - Outputs: in_ready=1, out_valid=0, csa_a=csa_b=0, csa_cin=0.
  - Reset wins over every other event, including mid-RUN and in DONE with out_ready=1. Any in-flight operation is discarded and no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_reg=op_a, b_reg=op_b, carry_reg=op_cin, idx=0, clear result to 0, state→RUN.
- RUN:
  - in_ready=0.
  - Combinational drive: csa_a=a_reg[4*idx+:4], csa_b=b_reg[4*idx+:4], csa_cin=carry_reg.
  - Each edge: result[4*idx+:4]<=csa_sum, carry_reg<=csa_cout, idx<=idx+1.
  - When idx==WORDS-1: also result_cout<=csa_cout, idx<=0, state→DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - result and result_cout are held stable while out_ready=0.
  - On out_ready=1: state→IDLE, out_valid deasserts next cycle.
  - No input acceptance in the same cycle as the output handshake (no overlap).
- In IDLE and DONE, csa_a, csa_b and csa_cin are driven to 0.
- Latency: accept edge at cycle T gives out_valid=1 in the cycle after edge T+WORDS (WORDS RUN cycles). Throughput is at most one operation per WORDS+2 cycles.
- idx width = clog2(WORDS), minimum 1 bit.
- WORDS=1: a single RUN cycle, then DONE.
- Arithmetic is unsigned modulo 2^W. The carry out of W bits appears only on result_cout.
- in_valid asserted while in_ready=0 is ignored. op_a, op_b and op_cin are sampled only at the accept edge, so changes after acceptance do not affect the result.
- out_ready asserted outside DONE is ignored.

Optional Feature:
- Macro: CSA_SEQ_OVF_EN.
- Defined:
  - Adds output port result_ovf (1 bit), the two's-complement signed overflow of the W-bit add.
  - Registered when state→DONE as (a_reg[W-1]==b_reg[W-1]) && (csa_sum[3]!=a_reg[W-1]), taken on the last RUN cycle.
  - Reset value 0; held with result in DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WORDS=4 with a behavioural csa model unless noted):
- op_a=0x1234, op_b=0x4321, op_cin=0, out_ready=1 → accepted; in_ready=0 for 4 RUN cycles; csa_a sequence 4,3,2,1; out_valid=1 exactly 4 cycles after the accept edge; result=0x5555, result_cout=0.
- op_a=0xFFFF, op_b=0x0001, op_cin=0 → carry ripples through every slice; csa_cin sequence 0,1,1,1; result=0x0000, result_cout=1.
- op_a=0x0F0F, op_b=0x00F1, op_cin=1 → result=0x1001, result_cout=0.
- Backpressure: after out_valid, hold out_ready=0 for 5 cycles while toggling op_a and in_valid → result stable, in_ready=0, no new accept. Then raise out_ready=1 for 1 cycle → IDLE, in_ready=1.
- Assert rst during the 2nd RUN cycle → next cycle state is IDLE with in_ready=1, out_valid=0, result=0, csa outputs 0. A following add 0x0001+0x0001 gives 0x0002 with no stale carry.
- CSA_SEQ_OVF_EN defined: 0x7FFF+0x0001 → result=0x8000, result_ovf=1. Then 0xFFFF+0x0001 → result_ovf=0, result_cout=1. Also rerun the first scenario with WORDS=1 (op_a=0x9, op_b=0x8) → result=0x1, result_cout=1, out_valid 1 cycle after accept.
